cal_sequencer: RTL and testbench
================================

// Module: cal_sequencer
// PURPOSE
//  Automatic calibration controller. Steps the LED-ID display/capture datapath through all LED IDs.
//  For each ID it shows the ID on the strand, waits for camera frames to settle, then triggers a capture.
//  It drives the user-interaction inputs of the calibration FSM (cal_rst, increment_id, capture_shown_frame, calibration_on).
//  Sits between the top-level buttons/UART commands and the calibration FSM, in the HDMI pixel clock domain.
// PARAMETERS
//  NUM_LEDS           50          LEDs on strand; IDs 0..NUM_LEDS-1
//  LED_ADDRESS_WIDTH  6           id port is LED_ADDRESS_WIDTH+1 bits; must satisfy NUM_LEDS < 2**(LED_ADDRESS_WIDTH+1)
//  SETTLE_FRAMES      2           camera frame_done pulses to skip after ID shown, before capture (>=1)
//  TIMEOUT_CYCLES     74_250_000  max cycles in any wait state (1 s @ 74.25 MHz); TW=$clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk                    in   1      system/pixel clock
//  rst_n                  in   1      async active-low reset
//  start                  in   1      1-cycle pulse: begin full calibration run
//  abort                  in   1      1-cycle pulse: stop run, return to IDLE
//  frame_done             in   1      1-cycle pulse per completed camera frame
//  displayed_frame_valid  in   1      level from cal FSM: LED strand has latched current ID frame
//  capture_done           in   1      1-cycle pulse: cal table write for captured frame finished
//  cal_rst                out  1      1-cycle pulse: reset cal FSM ID to 0
//  calibration_on         out  1      high while a run is active (SHOW..NEXT)
//  increment_id           out  1      1-cycle pulse: advance cal FSM to next ID
//  capture_shown_frame    out  1      1-cycle pulse: capture next camera frame
//  current_id             out  LED_ADDRESS_WIDTH+1  ID being calibrated
//  busy / done / error    out  1      run active / run completed ok / timeout (sticky until start)
//  error_id               out  LED_ADDRESS_WIDTH+1  current_id latched at timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; counters 0. Reset mid-run aborts silently (done=error=0).
//  All outputs registered; pulses are exactly 1 cycle.
//  States (cal_seq_state_t):
//   IDLE:       start -> INIT; cal_rst=1 in following cycle; clear done/error; current_id=0.
//   INIT:       1 cycle (cal_rst high) -> WAIT_SHOWN.
//   SHOW:       pulse increment_id for 1 cycle -> WAIT_SHOWN.
//   WAIT_SHOWN: wait displayed_frame_valid=1; clear frame counter; -> SETTLE.
//   SETTLE:     count frame_done; at count==SETTLE_FRAMES -> CAPTURE. frame_done on the cycle of entry is not counted.
//   CAPTURE:    pulse capture_shown_frame 1 cycle -> WAIT_CAP.
//   WAIT_CAP:   capture_done -> NEXT.
//   NEXT:       if current_id==NUM_LEDS-1 -> DONE (no increment_id pulse);
//               else current_id+=1 -> SHOW.
//   DONE:       done=1, calibration_on=0; start re-runs (-> INIT).
//   ERROR:      error=1; start re-runs, clearing error.
//  Latency per ID (ideal): 6 cycles + time to displayed_frame_valid + SETTLE_FRAMES frames + capture time.
//  Timeout: watchdog clears on every state change. In WAIT_SHOWN/SETTLE/WAIT_CAP, count reaching TIMEOUT_CYCLES-1 -> ERROR next cycle; error_id<=current_id.
//  abort: in any state except IDLE -> IDLE next cycle; calibration_on/busy drop; done/error unchanged.
//  Priority: rst_n > abort > timeout > normal transition. start outside IDLE/DONE/ERROR is ignored.
//  busy = calibration_on = (state in INIT..NEXT). current_id never exceeds NUM_LEDS-1.
// STRUCTURE
//  cal_pkg: cal_seq_state_t enum {IDLE,INIT,SHOW,WAIT_SHOWN,SETTLE,CAPTURE,WAIT_CAP,NEXT,DONE,ERROR}.
//  cal_pkg: localparams for default TIMEOUT_CYCLES and SETTLE_FRAMES.
//  Sub-module cal_watchdog (params LIMIT; in clk, rst_n, clear, enable; out expired): TW-bit counter, saturating.
//  Top: state register + next-state comb + output regs + current_id / frame counters.
// TESTING (NUM_LEDS=4, SETTLE_FRAMES=2, TIMEOUT_CYCLES=1000)
//  Normal run, responsive model:
//   -> cal_rst x1, increment_id x3, capture_shown_frame x4 with current_id 0,1,2,3.
//   -> done=1 and busy=0 after 4th capture_done; no 4th increment_id.
//  Settle count: frame_done pulse on SETTLE entry cycle plus 2 later
//   -> capture_shown_frame only after the 2nd later pulse.
//  Timeout: withhold capture_done for id 2
//   -> error=1, error_id=2 exactly 1000 cycles after WAIT_CAP entry; calibration_on=0.
//  Abort in SETTLE at id 1
//   -> IDLE next cycle; no further pulses; a following start gives cal_rst and restarts at id 0.
//  Async reset mid WAIT_CAP (rst_n low between clock edges)
//   -> all outputs 0 immediately; start and abort in the same cycle from IDLE -> stays IDLE.
//  Start while busy ignored; start from DONE reruns cleanly with done cleared.

Source files
------------

// File: rtl/cal_sequencer_pkg.sv
// Shared types and defaults for the LED calibration sequencer.
package cal_sequencer_pkg;

    localparam int unsigned CAL_NUM_LEDS_DEF          = 50;
    localparam int unsigned CAL_LED_ADDRESS_WIDTH_DEF = 6;
    localparam int unsigned CAL_SETTLE_FRAMES_DEF     = 2;
    localparam int unsigned CAL_TIMEOUT_CYCLES_DEF    = 74_250_000;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INIT       = 4'd1,
        SHOW       = 4'd2,
        WAIT_SHOWN = 4'd3,
        SETTLE     = 4'd4,
        CAPTURE    = 4'd5,
        WAIT_CAP   = 4'd6,
        NEXT       = 4'd7,
        DONE       = 4'd8,
        ERROR      = 4'd9
    } cal_seq_state_t;

    // States in which the sequencer is waiting on the outside world.
    function automatic logic is_wait_state(input cal_seq_state_t s);
        return (s == WAIT_SHOWN) || (s == SETTLE) || (s == WAIT_CAP);
    endfunction

    // States that make up an active calibration run.
    function automatic logic is_run_state(input cal_seq_state_t s);
        return s inside {INIT, SHOW, WAIT_SHOWN, SETTLE, CAPTURE, WAIT_CAP, NEXT};
    endfunction

endpackage

// File: rtl/cal_sequencer_if.sv
// Control/status bundle between the sequencer and the buttons, camera and calibration FSM.
interface cal_sequencer_if #(
    parameter int unsigned ID_W = 7
) ();

    logic            start;
    logic            abort;
    logic            frame_done;
    logic            displayed_frame_valid;
    logic            capture_done;
    logic            cal_rst;
    logic            calibration_on;
    logic            increment_id;
    logic            capture_shown_frame;
    logic [ID_W-1:0] current_id;
    logic            busy;
    logic            done;
    logic            error;
    logic [ID_W-1:0] error_id;

    modport master (
        input  start, abort, frame_done, displayed_frame_valid, capture_done,
        output cal_rst, calibration_on, increment_id, capture_shown_frame,
        output current_id, busy, done, error, error_id
    );

    modport slave (
        output start, abort, frame_done, displayed_frame_valid, capture_done,
        input  cal_rst, calibration_on, increment_id, capture_shown_frame,
        input  current_id, busy, done, error, error_id
    );

endinterface

// File: rtl/cal_sequencer_watchdog.sv
// Saturating cycle counter that flags a wait lasting LIMIT cycles.
module cal_sequencer_watchdog #(
    parameter int unsigned LIMIT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned    TW       = $clog2(LIMIT + 1);
    localparam logic [TW-1:0]  CNT_MAX  = TW'(LIMIT);
    localparam logic [TW-1:0]  CNT_FIRE = TW'(LIMIT - 1);

    logic [TW-1:0] count_q, count_d;
    logic          expired_q, expired_d;

    // Count enabled cycles, restart on clear, hold at the top value.
    always_comb begin
        count_d   = count_q;
        expired_d = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
        expired_d = enable_i && !clear_i && (count_d >= CNT_FIRE);
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/cal_sequencer.sv
// Steps the calibration FSM through every LED ID: show, settle, capture, advance.
module cal_sequencer
    import cal_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LEDS          = CAL_NUM_LEDS_DEF,
    parameter int unsigned LED_ADDRESS_WIDTH = CAL_LED_ADDRESS_WIDTH_DEF,
    parameter int unsigned SETTLE_FRAMES     = CAL_SETTLE_FRAMES_DEF,
    parameter int unsigned TIMEOUT_CYCLES    = CAL_TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    cal_sequencer_if.master bus
);

    localparam int unsigned     ID_W        = LED_ADDRESS_WIDTH + 1;
    localparam int unsigned     FW          = $clog2(SETTLE_FRAMES + 1);
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_LEDS - 1);
    localparam logic [FW-1:0]   SETTLE_LAST = FW'(SETTLE_FRAMES - 1);

    cal_seq_state_t  state_q, state_d;
    logic [ID_W-1:0] current_id_q, current_id_d;
    logic [ID_W-1:0] error_id_q, error_id_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            settle_first_q, settle_first_d;
    logic            cal_rst_q, cal_rst_d;
    logic            increment_id_q, increment_id_d;
    logic            capture_q, capture_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            wd_clear_c, wd_enable_c;
    logic            wd_expired;

    cal_sequencer_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear_c),
        .enable_i  (wd_enable_c),
        .expired_o (wd_expired)
    );

    // Next state, counters and next values of the registered outputs.
    always_comb begin
        state_d        = state_q;
        current_id_d   = current_id_q;
        error_id_d     = error_id_q;
        frame_cnt_d    = frame_cnt_q;
        done_d         = done_q;
        error_d        = error_q;
        settle_first_d = 1'b0;
        cal_rst_d      = 1'b0;
        increment_id_d = 1'b0;
        capture_d      = 1'b0;
        busy_d         = 1'b0;
        wd_clear_c     = 1'b0;
        wd_enable_c    = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
        end else if (wd_expired && is_wait_state(state_q)) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            error_id_d = current_id_q;
        end else begin
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state_d      = INIT;
                        current_id_d = '0;
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                    end
                end
                INIT:    state_d = WAIT_SHOWN;
                SHOW:    state_d = WAIT_SHOWN;
                WAIT_SHOWN: begin
                    if (bus.displayed_frame_valid) begin
                        state_d     = SETTLE;
                        frame_cnt_d = '0;
                    end
                end
                SETTLE: begin
                    // A frame ending on the entry cycle may predate the new ID, so skip it.
                    if (bus.frame_done && !settle_first_q) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        if (frame_cnt_q == SETTLE_LAST) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: state_d = WAIT_CAP;
                WAIT_CAP: begin
                    if (bus.capture_done) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (current_id_q == LAST_ID) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        current_id_d = current_id_q + 1'b1;
                        state_d      = SHOW;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        settle_first_d = (state_d == SETTLE) && (state_q != SETTLE);
        cal_rst_d      = (state_d == INIT);
        increment_id_d = (state_d == SHOW);
        capture_d      = (state_d == CAPTURE);
        busy_d         = is_run_state(state_d);
        wd_clear_c     = (state_d != state_q);
        wd_enable_c    = is_wait_state(state_q);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            current_id_q   <= '0;
            error_id_q     <= '0;
            frame_cnt_q    <= '0;
            settle_first_q <= 1'b0;
            cal_rst_q      <= 1'b0;
            increment_id_q <= 1'b0;
            capture_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            current_id_q   <= current_id_d;
            error_id_q     <= error_id_d;
            frame_cnt_q    <= frame_cnt_d;
            settle_first_q <= settle_first_d;
            cal_rst_q      <= cal_rst_d;
            increment_id_q <= increment_id_d;
            capture_q      <= capture_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign bus.cal_rst             = cal_rst_q;
    assign bus.increment_id        = increment_id_q;
    assign bus.capture_shown_frame = capture_q;
    assign bus.calibration_on      = busy_q;
    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.error               = error_q;
    assign bus.current_id          = current_id_q;
    assign bus.error_id            = error_id_q;

endmodule

// File: tb/tb_cal_sequencer.sv
// Self-checking bench: randomized camera/cal-FSM responder against an event-level reference model.
module tb_cal_sequencer;

    localparam int unsigned NUM_LEDS          = 4;
    localparam int unsigned LED_ADDRESS_WIDTH = 6;
    localparam int unsigned SETTLE_FRAMES     = 2;
    localparam int unsigned TIMEOUT_CYCLES    = 1000;
    localparam int unsigned ID_W              = LED_ADDRESS_WIDTH + 1;
    localparam int          EV_RST            = -1;
    localparam int          EV_INC            = -2;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cal_sequencer_if #(.ID_W(ID_W)) bus ();

    cal_sequencer #(
        .NUM_LEDS          (NUM_LEDS),
        .LED_ADDRESS_WIDTH (LED_ADDRESS_WIDTH),
        .SETTLE_FRAMES     (SETTLE_FRAMES),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ev_q[$];
    bit auto_resp, fd_en, dfv_seen;
    int withhold_id, rise_cyc, nfr, exp_cap_cyc, dfv_due, cap_due;
    int last_cap_cyc, last_cd_cyc;
    logic prev_rst, prev_inc, prev_cap, prev_fd, prev_busy;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: account inputs of the closed cycle, observe outputs, drive the responder.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.displayed_frame_valid && !dfv_seen) begin
            dfv_seen = 1'b1;
            rise_cyc = cyc;
            nfr      = 0;
        end
        // Frames count once the sequencer has spent one cycle in its settle phase.
        if (bus.frame_done && dfv_seen && (cyc >= rise_cyc + 2) && (nfr < int'(SETTLE_FRAMES))) begin
            nfr++;
            if (nfr == int'(SETTLE_FRAMES)) exp_cap_cyc = cyc + 1;
        end
        if (bus.capture_done) last_cd_cyc = cyc;
        cyc++;

        if (bus.cal_rst || bus.increment_id) begin
            ev_q.push_back(bus.cal_rst ? EV_RST : EV_INC);
            dfv_seen    = 1'b0;
            exp_cap_cyc = -1;
            if (auto_resp) begin
                bus.displayed_frame_valid = 1'b0;
                dfv_due = cyc + int'($urandom_range(1, 4));
            end
        end
        if (bus.capture_shown_frame) begin
            ev_q.push_back(int'(bus.current_id));
            check_eq("capture_cycle", cyc, exp_cap_cyc);
            last_cap_cyc = cyc;
            exp_cap_cyc  = -1;
            if (auto_resp && (int'(bus.current_id) != withhold_id))
                cap_due = cyc + int'($urandom_range(1, 6));
        end
        if (bus.cal_rst)             check_eq("cal_rst_width", int'(prev_rst), 0);
        if (bus.increment_id)        check_eq("increment_width", int'(prev_inc), 0);
        if (bus.capture_shown_frame) check_eq("capture_width", int'(prev_cap), 0);
        if (bus.busy != prev_busy)   check_eq("cal_on_vs_busy", int'(bus.calibration_on), int'(bus.busy));
        prev_rst  = bus.cal_rst;
        prev_inc  = bus.increment_id;
        prev_cap  = bus.capture_shown_frame;
        prev_busy = bus.busy;

        bus.frame_done   = 1'b0;
        bus.capture_done = 1'b0;
        if (auto_resp) begin
            if (!bus.displayed_frame_valid && (cyc == dfv_due)) bus.displayed_frame_valid = 1'b1;
            if (cyc == cap_due) bus.capture_done = 1'b1;
            if (fd_en && !prev_fd && ($urandom_range(0, 2) == 0)) bus.frame_done = 1'b1;
        end
        prev_fd = bus.frame_done;
    endtask

    task automatic start_run();
        ev_q.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !bus.done && !bus.error; i++) tick();
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget && ev_q.size() < n; i++) tick();
    endtask

    // Expected pulse order of a complete run: reset, then capture per ID with an increment between.
    task automatic check_events(input string tag, input int n_ids);
        int exp_q[$];
        exp_q.push_back(EV_RST);
        for (int id = 0; id < n_ids; id++) begin
            if (id > 0) exp_q.push_back(EV_INC);
            exp_q.push_back(id);
        end
        check_eq({tag, "_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            check_eq({tag, "_event"}, ev_q[i], exp_q[i]);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_cal_rst"},   int'(bus.cal_rst), 0);
        check_eq({tag, "_cal_on"},    int'(bus.calibration_on), 0);
        check_eq({tag, "_increment"}, int'(bus.increment_id), 0);
        check_eq({tag, "_capture"},   int'(bus.capture_shown_frame), 0);
        check_eq({tag, "_cur_id"},    int'(bus.current_id), 0);
        check_eq({tag, "_busy"},      int'(bus.busy), 0);
        check_eq({tag, "_done"},      int'(bus.done), 0);
        check_eq({tag, "_error"},     int'(bus.error), 0);
        check_eq({tag, "_error_id"},  int'(bus.error_id), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: bench stuck at cycle %0d", cyc);
        $fatal(1, "bench did not complete");
    end

    initial begin
        int npulse;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.frame_done = 1'b0;
        bus.displayed_frame_valid = 1'b0; bus.capture_done = 1'b0;
        auto_resp = 1'b1; fd_en = 1'b1; dfv_seen = 1'b0; withhold_id = -1;
        rise_cyc = 0; nfr = 0; exp_cap_cyc = -1; dfv_due = -1; cap_due = -1;
        last_cap_cyc = 0; last_cd_cyc = 0;
        prev_rst = 0; prev_inc = 0; prev_cap = 0; prev_fd = 0; prev_busy = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        #2 rst_n = 1'b1;
        tick();
        check_eq("idle_busy", int'(bus.busy), 0);

        // Normal run with start pulses sprinkled in while busy
        start_run();
        check_eq("a_cal_rst", int'(bus.cal_rst), 1);
        check_eq("a_busy", int'(bus.busy), 1);
        for (int i = 0; i < 2000 && !bus.done && !bus.error; i++) begin
            if ($urandom_range(0, 9) == 0) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        check_eq("a_done", int'(bus.done), 1);
        check_eq("a_busy_end", int'(bus.busy), 0);
        check_eq("a_cal_on_end", int'(bus.calibration_on), 0);
        check_eq("a_error", int'(bus.error), 0);
        check_eq("a_done_latency", cyc - last_cd_cyc, 2);
        check_events("a", int'(NUM_LEDS));

        // Rerun from DONE; first ID settles under hand-placed frame pulses
        auto_resp = 1'b0;
        bus.displayed_frame_valid = 1'b0;
        tick();
        check_eq("b_done_before", int'(bus.done), 1);
        start_run();
        check_eq("b_done_cleared", int'(bus.done), 0);
        check_eq("b_cal_rst", int'(bus.cal_rst), 1);
        check_eq("b_cur_id", int'(bus.current_id), 0);
        tick();
        bus.displayed_frame_valid = 1'b1;
        tick();
        bus.frame_done = 1'b1;
        tick();
        check_eq("b_settle_early1", int'(bus.capture_shown_frame), 0);
        tick();
        bus.frame_done = 1'b1;
        tick();
        check_eq("b_settle_early2", int'(bus.capture_shown_frame), 0);
        tick();
        check_eq("b_settle_early3", int'(bus.capture_shown_frame), 0);
        bus.frame_done = 1'b1;
        tick();
        check_eq("b_settle_capture", int'(bus.capture_shown_frame), 1);
        check_eq("b_capture_id", int'(bus.current_id), 0);
        tick();
        bus.capture_done = 1'b1;
        auto_resp = 1'b1;
        wait_end(2000);
        check_eq("b_done", int'(bus.done), 1);
        check_events("b", int'(NUM_LEDS));

        // Timeout while waiting for capture_done on ID 2
        withhold_id = 2;
        start_run();
        wait_end(1500);
        check_eq("c_error", int'(bus.error), 1);
        check_eq("c_error_id", int'(bus.error_id), 2);
        check_eq("c_error_latency", cyc - last_cap_cyc, int'(TIMEOUT_CYCLES) + 1);
        check_eq("c_cal_on", int'(bus.calibration_on), 0);
        check_eq("c_busy", int'(bus.busy), 0);
        check_eq("c_done", int'(bus.done), 0);
        check_events("c", 3);
        withhold_id = -1;

        // Rerun from ERROR, abort while settling on ID 1, then restart
        start_run();
        check_eq("d_error_cleared", int'(bus.error), 0);
        check_eq("d_cal_rst", int'(bus.cal_rst), 1);
        wait_events(3, 500);
        check_eq("d_reached_inc", ev_q.size(), 3);
        fd_en = 1'b0;
        for (int i = 0; i < 200 && !dfv_seen; i++) tick();
        check_eq("d_settle_id", int'(bus.current_id), 1);
        check_eq("d_settle_busy", int'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("d_abort_busy", int'(bus.busy), 0);
        check_eq("d_abort_cal_on", int'(bus.calibration_on), 0);
        check_eq("d_abort_done", int'(bus.done), 0);
        check_eq("d_abort_error", int'(bus.error), 0);
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            npulse += int'(bus.cal_rst) + int'(bus.increment_id) + int'(bus.capture_shown_frame);
        end
        check_eq("d_no_pulses", npulse, 0);
        fd_en = 1'b1;
        start_run();
        check_eq("d_restart_cal_rst", int'(bus.cal_rst), 1);
        check_eq("d_restart_id", int'(bus.current_id), 0);
        wait_end(2000);
        check_eq("d_done", int'(bus.done), 1);
        check_events("d", int'(NUM_LEDS));

        // Asynchronous reset in the middle of a capture wait
        withhold_id = 0;
        start_run();
        wait_events(2, 500);
        check_eq("e_captured", ev_q.size(), 2);
        repeat (3) tick();
        check_eq("e_busy_pre", int'(bus.busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check_quiet_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        withhold_id = -1;
        ev_q.delete();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("e_start_abort_busy", int'(bus.busy), 0);
        repeat (5) tick();
        check_eq("e_stays_idle", int'(bus.busy), 0);
        check_eq("e_no_events", ev_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
